terminal_host_port: RTL

- Host-side endpoint attached to one X-side terminal channel of test_engine_network_core.
- TX half: buffers host flits and drives them onto the core's xneg/xpos inport channel under credit-based flow control, consuming credits returned on that channel's credits line.
- RX half: buffers flits arriving from the core's outport channel and returns one credit per flit popped by the host.
- One instance per terminal channel; Y_WIDTH instances per X side.

---
 rtl/terminal_host_port.sv | 133 +++++++++++++
 1 files changed

// File: rtl/terminal_host_port.sv
// Host endpoint for one X-side terminal channel: credit-flow-controlled TX FIFO toward the core,
// RX FIFO from the core with one credit returned per host pop.
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 16
`endif

module terminal_host_port #(
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned TX_DEPTH     = 4,
    parameter int unsigned RX_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [0:`CHANNEL_WIDTH-1]             tx_flit_din,
    input  logic                                  tx_valid_din,
    output logic                                  tx_ready_dout,
    output logic [0:`CHANNEL_WIDTH-1]             channel_dout,
    input  logic                                  credit_in_din,
    input  logic [0:`CHANNEL_WIDTH-1]             channel_din,
    output logic                                  credit_out_dout,
    output logic [0:`CHANNEL_WIDTH-1]             rx_flit_dout,
    output logic                                  rx_valid_dout,
    input  logic                                  rx_ready_din,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]     tx_credits_dout,
    output logic                                  credit_err_dout,
    output logic                                  rx_overflow_dout
);

    localparam int unsigned CW  = `CHANNEL_WIDTH;
    localparam int unsigned CRW = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);

    logic [0:CW-1]  tx_mem [TX_DEPTH];
    logic [0:CW-1]  rx_mem [RX_DEPTH];

    logic [TAW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RAW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CRW-1:0] credits_q, credits_d;
    logic [0:CW-1]  channel_q, channel_d;
    logic           credit_out_q, credit_out_d;
    logic           credit_err_q, credit_err_d;
    logic           rx_ovf_q, rx_ovf_d;

    logic tx_full, tx_empty, tx_push, tx_send;
    logic rx_full, rx_empty, rx_push, rx_pop;

    always_comb begin
        tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
        tx_empty = (tx_wr_q == tx_rd_q);
        rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
        rx_empty = (rx_wr_q == rx_rd_q);

        tx_push  = tx_valid_din & ~tx_full;
        tx_send  = ~tx_empty & (credits_q != '0);
        rx_pop   = ~rx_empty & rx_ready_din;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the flit.
        rx_push  = channel_din[0] & (~rx_full | rx_pop);
    end

    always_comb begin
        tx_wr_d      = tx_wr_q + {{TAW{1'b0}}, tx_push};
        tx_rd_d      = tx_rd_q + {{TAW{1'b0}}, tx_send};
        rx_wr_d      = rx_wr_q + {{RAW{1'b0}}, rx_push};
        rx_rd_d      = rx_rd_q + {{RAW{1'b0}}, rx_pop};
        credit_out_d = rx_pop;
        rx_ovf_d     = rx_ovf_q | (channel_din[0] & rx_full & ~rx_pop);

        channel_d = '0;
        if (tx_send) begin
            channel_d    = tx_mem[tx_rd_q[TAW-1:0]];
            channel_d[0] = 1'b1;
        end

        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        case ({tx_send, credit_in_din})
            2'b10: credits_d = credits_q - CRW'(1);
            2'b01: begin
                if (credits_q == CRW'(BUFFER_DEPTH)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CRW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            credits_q    <= CRW'(BUFFER_DEPTH);
            channel_q    <= '0;
            credit_out_q <= 1'b0;
            credit_err_q <= 1'b0;
            rx_ovf_q     <= 1'b0;
        end else begin
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            credits_q    <= credits_d;
            channel_q    <= channel_d;
            credit_out_q <= credit_out_d;
            credit_err_q <= credit_err_d;
            rx_ovf_q     <= rx_ovf_d;
        end
    end

    // Storage arrays need no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q[TAW-1:0]] <= tx_flit_din;
        end
        if (rx_push) begin
            rx_mem[rx_wr_q[RAW-1:0]] <= channel_din;
        end
    end

    assign tx_ready_dout    = ~tx_full;
    assign channel_dout     = channel_q;
    assign credit_out_dout  = credit_out_q;
    assign rx_flit_dout     = rx_mem[rx_rd_q[RAW-1:0]];
    assign rx_valid_dout    = ~rx_empty;
    assign tx_credits_dout  = credits_q;
    assign credit_err_dout  = credit_err_q;
    assign rx_overflow_dout = rx_ovf_q;

endmodule
